back1_cpu_vbus_master: RTL and testbench

BACK1_CPU_VBUS_MASTER -- requirements
Module: back1_cpu_vbus_master

---
 rtl/back1_cpu_vbus_master_if.sv | 37 +++
 rtl/back1_cpu_vbus_master.sv | 175 +++++++++++++++++
 tb/tb_back1_cpu_vbus_master.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/back1_cpu_vbus_master_if.sv
// CPU request/ack handshake and BACK1 video-bus pins shared by the CPU bridge and its environment.
interface back1_cpu_vbus_master_if;
  logic        cpu_req;
  logic        cpu_we;
  logic [12:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_busy;
  logic        cpu_ack;
  logic [7:0]  cpu_rdata;
  logic        cpu_err;
  logic [7:0]  VD_out;
  logic [7:0]  VD_in;
  logic        V_C;
  logic [11:0] VA;
  logic        BACK1_VRAM_CSn;
  logic        VDG;
  logic        VOE;
  logic        VWE;
  logic        VRD;
  logic        B1SY;
  logic        B1SX;
  logic        B1Y8;
  logic        B1X8;
  logic [1:0]  B1_TILEBANK;

  modport master (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, VD_in, V_C,
    output cpu_busy, cpu_ack, cpu_rdata, cpu_err, VD_out, VA,
           BACK1_VRAM_CSn, VDG, VOE, VWE, VRD, B1SY, B1SX, B1Y8, B1X8, B1_TILEBANK
  );

  modport slave (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, VD_in, V_C,
    input  cpu_busy, cpu_ack, cpu_rdata, cpu_err, VD_out, VA,
           BACK1_VRAM_CSn, VDG, VOE, VWE, VRD, B1SY, B1SX, B1Y8, B1X8, B1_TILEBANK
  );
endinterface

// File: rtl/back1_cpu_vbus_master.sv
// CPU bridge to the BACK1 layer: scroll/control registers plus slot-arbitrated VRAM access.
// Optional macro BACK1_CPUIF_SLOT_TIMEOUT_EN aborts a VRAM access that never gets a CPU slot.
module back1_cpu_vbus_master (
  input  logic                    clk,
  input  logic                    VIDEO_RSTn,
  back1_cpu_vbus_master_if.master bus
);
  typedef enum logic [2:0] {
    IDLE, REG_SETUP, REG_STROBE, WAIT_SLOT, ACCESS, CAPTURE, DONE
  } state_t;

  state_t      state;
  logic [11:0] off_p0;
  logic [7:0]  wdata_p0;
  logic        we_p0;
  logic [7:0]  scroll_y;
  logic [7:0]  scroll_x;
  logic [7:0]  reg_rd;

`ifdef BACK1_CPUIF_SLOT_TIMEOUT_EN
  logic [7:0]  slot_cnt;
  logic        err_q;
  assign bus.cpu_err = err_q;
`else
  assign bus.cpu_err = 1'b0;
`endif

  // request capture: cpu_req is a one-cycle pulse, so the operands are held here
  always_ff @(posedge clk) begin
    if (state == IDLE && bus.cpu_req) begin
      off_p0   <= bus.cpu_addr[11:0];
      wdata_p0 <= bus.cpu_wdata;
      we_p0    <= bus.cpu_we;
    end
  end

  always_comb begin
    case (off_p0)
      12'd0:   reg_rd = scroll_y;
      12'd1:   reg_rd = scroll_x;
      12'd2:   reg_rd = {2'b00, bus.B1_TILEBANK, 2'b00, bus.B1X8, bus.B1Y8};
      default: reg_rd = 8'hFF;
    endcase
  end

  always_ff @(posedge clk or negedge VIDEO_RSTn) begin
    if (!VIDEO_RSTn) begin
      state              <= IDLE;
      bus.cpu_busy       <= 1'b0;
      bus.cpu_ack        <= 1'b0;
      bus.cpu_rdata      <= 8'hFF;
      scroll_y           <= 8'h00;
      scroll_x           <= 8'h00;
      bus.B1Y8           <= 1'b0;
      bus.B1X8           <= 1'b0;
      bus.B1_TILEBANK    <= 2'b00;
      bus.VA             <= 12'h000;
      bus.BACK1_VRAM_CSn <= 1'b1;
      bus.VDG            <= 1'b1;
      bus.VOE            <= 1'b1;
      bus.VWE            <= 1'b1;
      bus.VRD            <= 1'b0;
      bus.B1SY           <= 1'b0;
      bus.B1SX           <= 1'b0;
      bus.VD_out         <= 8'hFF;
`ifdef BACK1_CPUIF_SLOT_TIMEOUT_EN
      slot_cnt           <= 8'd0;
      err_q              <= 1'b0;
`endif
    end else begin
      bus.cpu_ack <= 1'b0;
      bus.B1SY    <= 1'b0;
      bus.B1SX    <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.cpu_req) begin
            bus.cpu_busy <= 1'b1;
            if (bus.cpu_addr[12]) begin
              state <= REG_SETUP;
              if (bus.cpu_we && bus.cpu_addr[11:1] == 11'd0) bus.VD_out <= bus.cpu_wdata;
            end else begin
              state <= WAIT_SLOT;
`ifdef BACK1_CPUIF_SLOT_TIMEOUT_EN
              slot_cnt <= 8'd0;
`endif
            end
          end
        end
        REG_SETUP: begin
          if (!we_p0) begin
            bus.cpu_rdata <= reg_rd;
            bus.cpu_ack   <= 1'b1;
            state         <= DONE;
          end else if (off_p0 == 12'd0) begin
            scroll_y <= wdata_p0;
            bus.B1SY <= 1'b1;
            state    <= REG_STROBE;
          end else if (off_p0 == 12'd1) begin
            scroll_x <= wdata_p0;
            bus.B1SX <= 1'b1;
            state    <= REG_STROBE;
          end else begin
            if (off_p0 == 12'd2) begin
              bus.B1Y8        <= wdata_p0[0];
              bus.B1X8        <= wdata_p0[1];
              bus.B1_TILEBANK <= wdata_p0[5:4];
            end
            bus.cpu_ack <= 1'b1;
            state       <= DONE;
          end
        end
        REG_STROBE: begin
          bus.VD_out  <= 8'hFF;
          bus.cpu_ack <= 1'b1;
          state       <= DONE;
        end
        WAIT_SLOT: begin
          if (bus.V_C) begin
            state              <= ACCESS;
            bus.VA             <= off_p0;
            bus.BACK1_VRAM_CSn <= 1'b0;
            bus.VDG            <= 1'b0;
            bus.VRD            <= we_p0;
            bus.VWE            <= !we_p0;
            bus.VOE            <= we_p0;
            if (we_p0) bus.VD_out <= wdata_p0;
          end
`ifdef BACK1_CPUIF_SLOT_TIMEOUT_EN
          // count 254 marks the 255th cycle spent waiting for a slot
          else if (slot_cnt == 8'd254) begin
            bus.cpu_rdata <= 8'hFF;
            bus.cpu_ack   <= 1'b1;
            err_q         <= 1'b1;
            state         <= DONE;
          end else begin
            slot_cnt <= slot_cnt + 8'd1;
          end
`endif
        end
        ACCESS: begin
          if (we_p0) begin
            bus.BACK1_VRAM_CSn <= 1'b1;
            bus.VDG            <= 1'b1;
            bus.VOE            <= 1'b1;
            bus.VWE            <= 1'b1;
            bus.VRD            <= 1'b0;
            bus.VD_out         <= 8'hFF;
            bus.cpu_ack        <= 1'b1;
            state              <= DONE;
          end else begin
            state <= CAPTURE;
          end
        end
        CAPTURE: begin
          bus.cpu_rdata      <= bus.VD_in;
          bus.BACK1_VRAM_CSn <= 1'b1;
          bus.VDG            <= 1'b1;
          bus.VOE            <= 1'b1;
          bus.VWE            <= 1'b1;
          bus.VRD            <= 1'b0;
          bus.cpu_ack        <= 1'b1;
          state              <= DONE;
        end
        DONE: begin
          bus.cpu_busy <= 1'b0;
          state        <= IDLE;
`ifdef BACK1_CPUIF_SLOT_TIMEOUT_EN
          err_q        <= 1'b0;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_back1_cpu_vbus_master.sv
// Bench for back1_cpu_vbus_master: transaction-level expected-output model plus literal spot checks.
module tb_back1_cpu_vbus_master;
  logic clk = 1'b0;
  logic VIDEO_RSTn;
  always #5 clk = ~clk;

  back1_cpu_vbus_master_if bus();
  back1_cpu_vbus_master dut (.clk(clk), .VIDEO_RSTn(VIDEO_RSTn), .bus(bus));

  logic [7:0] vram [0:4095];
  assign bus.VD_in = vram[bus.VA];

  typedef struct packed {
    logic       busy, ack, csn, vdg, voe, vwe, vrd;
    logic [7:0] vd;
    logic       sy, sx, y8, x8;
    logic [1:0] tb;
    logic       err;
    logic [11:0] va;
    logic [7:0] rd;
  } frame_t;
  typedef struct { frame_t f; bit rd_chk; } exp_t;

  exp_t q[$];
  bit   model_on = 1'b0;
  int   total = 0, bad = 0;
  int   cyc = 0, ack_cnt = 0, ack_cyc = 0, csn_cnt = 0, sy_cnt = 0, req_cyc = 0;
  logic [7:0]  m_sy, m_sx, m_ctrl;
  logic [11:0] m_va;

  function automatic frame_t idle_f();
    frame_t f;
    f.busy = 0; f.ack = 0; f.csn = 1; f.vdg = 1; f.voe = 1; f.vwe = 1; f.vrd = 0;
    f.vd = 8'hFF; f.sy = 0; f.sx = 0;
    f.y8 = m_ctrl[0]; f.x8 = m_ctrl[1]; f.tb = m_ctrl[5:4];
    f.err = 0; f.va = m_va; f.rd = 8'hFF;
    return f;
  endfunction

  function automatic frame_t busy_f();
    frame_t f = idle_f();
    f.busy = 1;
    return f;
  endfunction

  function automatic string fmt(frame_t f);
    return $sformatf("busy=%b ack=%b csn=%b vdg=%b voe=%b vwe=%b vrd=%b vd=%h sy=%b sx=%b y8=%b x8=%b tb=%0d err=%b va=%h rdata=%h",
                     f.busy, f.ack, f.csn, f.vdg, f.voe, f.vwe, f.vrd, f.vd, f.sy, f.sx, f.y8, f.x8, f.tb, f.err, f.va, f.rd);
  endfunction

  task automatic push(input frame_t f, input bit rc);
    exp_t e;
    e.f = f; e.rd_chk = rc;
    q.push_back(e);
  endtask

  task automatic chk(input string name, input int act, input int want);
    total++;
    if (act != want) begin
      bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, want);
    end
  endtask

  task automatic mon_cycle();
    frame_t a;
    exp_t   e;
    cyc++;
    if (bus.cpu_ack) begin ack_cnt++; ack_cyc = cyc; end
    if (!bus.BACK1_VRAM_CSn) csn_cnt++;
    if (bus.B1SY) sy_cnt++;
    if (model_on) begin
      if (q.size() > 0) e = q.pop_front();
      else begin e.f = idle_f(); e.rd_chk = 0; end
      a.busy = bus.cpu_busy; a.ack = bus.cpu_ack; a.csn = bus.BACK1_VRAM_CSn;
      a.vdg = bus.VDG; a.voe = bus.VOE; a.vwe = bus.VWE; a.vrd = bus.VRD;
      a.vd = bus.VD_out; a.sy = bus.B1SY; a.sx = bus.B1SX; a.y8 = bus.B1Y8;
      a.x8 = bus.B1X8; a.tb = bus.B1_TILEBANK; a.err = bus.cpu_err; a.va = bus.VA;
      a.rd = e.rd_chk ? bus.cpu_rdata : e.f.rd;
      total++;
      if (a !== e.f) begin
        bad++;
        $display("FAIL frame cyc=%0d got {%s} required {%s}", cyc, fmt(a), fmt(e.f));
      end
    end
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 1000) begin @(negedge clk); n++; end
    chk("drain_bound", q.size(), 0);
    q.delete();
  endtask

  task automatic reg_op(input bit we, input logic [11:0] off, input logic [7:0] d);
    frame_t f;
    logic [7:0] r;
    @(posedge clk); #1;
    push(idle_f(), 0);
    req_cyc = cyc + 1;
    if (we && off <= 12'd1) begin
      f = busy_f(); f.vd = d; push(f, 0);
      f.sy = (off == 12'd0); f.sx = (off == 12'd1); push(f, 0);
      if (off == 12'd0) m_sy = d; else m_sx = d;
      f = busy_f(); f.ack = 1; push(f, 0);
    end else if (we) begin
      push(busy_f(), 0);
      if (off == 12'd2) m_ctrl = d & 8'b0011_0011;
      f = busy_f(); f.ack = 1; push(f, 0);
    end else begin
      push(busy_f(), 0);
      r = (off == 12'd0) ? m_sy : (off == 12'd1) ? m_sx : (off == 12'd2) ? m_ctrl : 8'hFF;
      f = busy_f(); f.ack = 1; f.rd = r; push(f, 1);
    end
    bus.cpu_req = 1; bus.cpu_we = we; bus.cpu_addr = {1'b1, off}; bus.cpu_wdata = d;
    @(posedge clk); #1;
    bus.cpu_req = 0; bus.cpu_we = ~we; bus.cpu_addr = 13'h1FFF; bus.cpu_wdata = ~d;
    drain();
  endtask

  task automatic vram_op(input bit we, input logic [11:0] a, input logic [7:0] d,
                         input int wait_n, input bit ign);
    frame_t f;
    @(posedge clk); #1;
    push(idle_f(), 0);
    req_cyc = cyc + 1;
    for (int k = 0; k <= wait_n; k++) push(busy_f(), 0);
    m_va = a;
    f = busy_f(); f.csn = 0; f.vdg = 0;
    if (we) begin f.vrd = 1; f.vwe = 0; f.voe = 1; f.vd = d; end
    else    begin f.voe = 0; end
    push(f, 0);
    if (!we) push(f, 0);
    f = busy_f(); f.ack = 1;
    if (!we) f.rd = vram[a];
    push(f, !we);
    bus.cpu_req = 1; bus.cpu_we = we; bus.cpu_addr = {1'b0, a}; bus.cpu_wdata = d; bus.V_C = 0;
    @(posedge clk); #1;
    bus.cpu_req = 0; bus.cpu_we = ~we; bus.cpu_addr = 13'h1FFF; bus.cpu_wdata = ~d;
    for (int k = 1; k <= wait_n + 1; k++) begin
      bus.V_C = (k == wait_n + 1);
      bus.cpu_req = (ign && k == 2);
      @(posedge clk); #1;
    end
    bus.V_C = 0; bus.cpu_req = 0;
    drain();
  endtask

  initial begin
    int a0, c0, s0;
    frame_t f;
    for (int i = 0; i < 4096; i++) vram[i] = i[7:0] ^ 8'hA5;
    vram[12'h123] = 8'h7E;
    m_sy = 0; m_sx = 0; m_ctrl = 0; m_va = 0;
    VIDEO_RSTn = 0;
    bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_addr = 0; bus.cpu_wdata = 0; bus.V_C = 0;
    fork
      forever begin @(negedge clk); mon_cycle(); end
    join_none

    repeat (2) @(negedge clk);
    chk("rst_busy", bus.cpu_busy, 0);
    chk("rst_ack", bus.cpu_ack, 0);
    chk("rst_rdata", bus.cpu_rdata, 8'hFF);
    chk("rst_err", bus.cpu_err, 0);
    chk("rst_csn", bus.BACK1_VRAM_CSn, 1);
    chk("rst_vd_out", bus.VD_out, 8'hFF);
    chk("rst_va", bus.VA, 0);
    chk("rst_tilebank", bus.B1_TILEBANK, 0);
    @(posedge clk); #1;
    VIDEO_RSTn = 1;
    model_on = 1;

    s0 = sy_cnt;
    reg_op(1, 12'h000, 8'h5A);
    chk("scrolly_latency", ack_cyc - req_cyc, 3);
    chk("scrolly_b1sy_pulses", sy_cnt - s0, 1);
    reg_op(1, 12'h001, 8'hC6);
    reg_op(1, 12'h002, 8'h31);
    chk("ctrl_latency", ack_cyc - req_cyc, 2);
    chk("ctrl_b1y8", bus.B1Y8, 1);
    chk("ctrl_b1x8", bus.B1X8, 0);
    chk("ctrl_tilebank", bus.B1_TILEBANK, 3);
    reg_op(0, 12'h002, 8'h00);
    chk("ctrl_readback", bus.cpu_rdata, 8'h31);
    reg_op(0, 12'h000, 8'h00);
    chk("scrolly_readback", bus.cpu_rdata, 8'h5A);
    reg_op(0, 12'h001, 8'h00);
    chk("scrollx_readback", bus.cpu_rdata, 8'hC6);
    reg_op(1, 12'h7FF, 8'hAA);
    reg_op(0, 12'h003, 8'h00);
    chk("noop_readback", bus.cpu_rdata, 8'hFF);

    c0 = csn_cnt;
    vram_op(1, 12'hABC, 8'hC3, 10, 0);
    chk("vram_wr_latency", ack_cyc - req_cyc, 13);
    chk("vram_wr_csn_cycles", csn_cnt - c0, 1);

    c0 = csn_cnt; a0 = ack_cnt;
    vram_op(0, 12'h123, 8'h00, 2, 1);
    repeat (4) @(negedge clk);
    chk("vram_rd_single_ack", ack_cnt - a0, 1);
    chk("vram_rd_latency", ack_cyc - req_cyc, 6);
    chk("vram_rd_data", bus.cpu_rdata, 8'h7E);
    chk("vram_rd_csn_cycles", csn_cnt - c0, 2);

`ifdef BACK1_CPUIF_SLOT_TIMEOUT_EN
    @(posedge clk); #1;
    push(idle_f(), 0);
    req_cyc = cyc + 1;
    for (int k = 0; k < 255; k++) push(busy_f(), 0);
    f = busy_f(); f.ack = 1; f.err = 1; f.rd = 8'hFF; push(f, 1);
    bus.cpu_req = 1; bus.cpu_we = 1; bus.cpu_addr = 13'h0200; bus.cpu_wdata = 8'h44; bus.V_C = 0;
    @(posedge clk); #1;
    bus.cpu_req = 0;
    drain();
    chk("timeout_latency", ack_cyc - req_cyc, 256);
    chk("timeout_rdata", bus.cpu_rdata, 8'hFF);
`else
    vram_op(1, 12'h200, 8'h44, 300, 0);
    chk("long_wait_latency", ack_cyc - req_cyc, 303);
`endif

    model_on = 0;
    @(posedge clk); #1;
    a0 = ack_cnt;
    bus.cpu_req = 1; bus.cpu_we = 1; bus.cpu_addr = 13'h0055; bus.cpu_wdata = 8'h99; bus.V_C = 1;
    @(posedge clk); #1;
    bus.cpu_req = 0;
    @(posedge clk); #1;
    chk("pre_rst_csn", bus.BACK1_VRAM_CSn, 0);
    chk("pre_rst_vwe", bus.VWE, 0);
    VIDEO_RSTn = 0;
    #1;
    chk("async_rst_csn", bus.BACK1_VRAM_CSn, 1);
    chk("async_rst_vwe", bus.VWE, 1);
    chk("async_rst_busy", bus.cpu_busy, 0);
    chk("async_rst_vd_out", bus.VD_out, 8'hFF);
    bus.V_C = 0;
    repeat (2) @(posedge clk);
    #1;
    VIDEO_RSTn = 1;
    repeat (6) @(posedge clk);
    #1;
    chk("rst_abort_no_ack", ack_cnt - a0, 0);
    chk("rst_abort_busy", bus.cpu_busy, 0);
    m_sy = 0; m_sx = 0; m_ctrl = 0; m_va = 0;
    model_on = 1;
    reg_op(0, 12'h002, 8'h00);
    chk("post_rst_ctrl", bus.cpu_rdata, 8'h00);
    chk("post_rst_latency", ack_cyc - req_cyc, 2);
    reg_op(0, 12'h000, 8'h00);
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
